// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner for a packed BCD value, with leading-zero blanking,
// an invalid-digit flag and tear-free value swaps at frame boundaries.
module bcd_display_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  err
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int AW = $clog2(DIGITS);

    logic [PW-1:0]         r_pcnt;
    logic [AW-1:0]         r_ptr;
    logic [4*DIGITS-1:0]   r_active;
    logic [4*DIGITS-1:0]   r_pending;
    logic                  r_pend_valid;
    logic [6:0]            r_seg;
    logic [DIGITS-1:0]     r_an;
    logic                  r_frame_done;
    logic                  r_err;

    logic                  w_tick;
    logic                  w_wrap;
    logic [PW-1:0]         w_pcnt_nxt;
    logic [AW-1:0]         w_ptr_nxt;
    logic [4*DIGITS-1:0]   w_active_nxt;
    logic [DIGITS-1:0]     w_an_nxt;
    logic [6:0]            w_seg_nxt;
    logic                  w_err_nxt;
    logic [3:0]            w_digit;
    logic                  w_blank;
    logic [DIGITS-1:0]     w_hi_nz;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b1000000;
        endcase
    endfunction

    assign w_tick     = (r_pcnt == PW'(PRESCALE - 1));
    assign w_wrap     = w_tick && (r_ptr == AW'(DIGITS - 1));
    assign w_pcnt_nxt = w_tick ? '0 : r_pcnt + PW'(1);

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_tick)
            w_ptr_nxt = (r_ptr == AW'(DIGITS - 1)) ? '0 : r_ptr + AW'(1);
    end

    // A load coinciding with the wrap edge bypasses the pending register so it
    // shows in the frame that starts on that very edge.
    always_comb begin
        w_active_nxt = r_active;
        if (w_wrap) begin
            if (load)
                w_active_nxt = bcd_in;
            else if (r_pend_valid)
                w_active_nxt = r_pending;
        end
    end

    // Outputs are decoded from the post-edge pointer/value so the display never lags.
    always_comb begin
        w_an_nxt  = '0;
        w_digit   = '0;
        w_blank   = 1'b0;
        w_err_nxt = 1'b0;
        w_hi_nz   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_hi_nz[i] = (w_active_nxt[4*i +: 4] != 4'd0) ||
                         ((i < DIGITS - 1) ? w_hi_nz[(i < DIGITS - 1) ? i + 1 : i] : 1'b0);
            w_err_nxt  = w_err_nxt | (w_active_nxt[4*i +: 4] > 4'd9);
        end
        for (int i = 0; i < DIGITS; i++) begin
            w_an_nxt[i] = (w_ptr_nxt == AW'(i));
            if (w_ptr_nxt == AW'(i)) begin
                w_digit = w_active_nxt[4*i +: 4];
                w_blank = (BLANK_LZ != 0) && (i > 0) && !w_hi_nz[i];
            end
        end
        w_seg_nxt = w_blank ? 7'b0000000 : seg7(w_digit);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_pcnt       <= '0;
            r_ptr        <= '0;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
            r_seg        <= '0;
            r_an         <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_pcnt       <= w_pcnt_nxt;
            r_ptr        <= w_ptr_nxt;
            r_active     <= w_active_nxt;
            if (w_wrap) begin
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pending    <= bcd_in;
                r_pend_valid <= 1'b1;
            end
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
            r_frame_done <= w_wrap;
            r_err        <= w_err_nxt;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: scan timing, blanking, err, tear-free loads,
// asynchronous reset and the unblanked variant.
module tb_bcd_display_scanner;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        load_a, load_b;
    logic [15:0] bcd_a, bcd_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic        fd_a, fd_b, err_a, err_b;

    logic        sel;
    logic [6:0]  o_seg;
    logic [3:0]  o_an;
    logic        o_fd, o_err;

    int n_assert = 0;
    int n_fail   = 0;
    int n_steps;

    always #5 CLK = ~CLK;

    bcd_display_scanner #(.DIGITS(4), .PRESCALE(4), .BLANK_LZ(1)) u_dut (
        .CLK(CLK), .Reset(Reset), .load(load_a), .bcd_in(bcd_a),
        .seg(seg_a), .an(an_a), .frame_done(fd_a), .err(err_a)
    );

    bcd_display_scanner #(.DIGITS(4), .PRESCALE(4), .BLANK_LZ(0)) u_nb (
        .CLK(CLK), .Reset(Reset), .load(load_b), .bcd_in(bcd_b),
        .seg(seg_b), .an(an_b), .frame_done(fd_b), .err(err_b)
    );

    assign o_seg = sel ? seg_b : seg_a;
    assign o_an  = sel ? an_b  : an_a;
    assign o_fd  = sel ? fd_b  : fd_a;
    assign o_err = sel ? err_b : err_a;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (o_fd !== 1'b1 && n < 64);
        chk("wait_frame_done", {31'd0, o_fd}, 32'd1);
    endtask

    // Entered on the sample just after a wrap edge; leaves on the sample after the next one.
    task automatic check_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic e);
        logic [6:0] sv [4];
        sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("%s an d%0d c%0d", name, d, c), {28'd0, o_an}, 32'd1 << d);
                chk($sformatf("%s seg d%0d c%0d", name, d, c), {25'd0, o_seg}, {25'd0, sv[d]});
                chk($sformatf("%s err d%0d c%0d", name, d, c), {31'd0, o_err}, {31'd0, e});
                chk($sformatf("%s fd d%0d c%0d", name, d, c), {31'd0, o_fd},
                    {31'd0, (d == 0 && c == 0)});
                step();
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        Reset = 1'b1; load_a = 1'b0; load_b = 1'b0; bcd_a = '0; bcd_b = '0;
        #1;
        chk("rst seg", {25'd0, seg_a}, 32'd0);
        chk("rst an", {28'd0, an_a}, 32'd0);
        chk("rst fd", {31'd0, fd_a}, 32'd0);
        chk("rst err", {31'd0, err_a}, 32'd0);
        step(); step();
        Reset = 1'b0;

        // 1/2: first edge, load 0x0042 at edge 2, blanking and scan timing
        step();
        chk("edge1 an", {28'd0, an_a}, 32'h1);
        chk("edge1 seg", {25'd0, seg_a}, 32'h3F);
        load_a = 1'b1; bcd_a = 16'h0042;
        step();
        load_a = 1'b0;
        wait_fd(n_steps);
        chk("first wrap at edge 16", n_steps, 32'd14);
        check_frame("v0042", 7'b1011011, 7'b1100110, 7'b0000000, 7'b0000000, 1'b0);

        // 3: invalid digit, embedded zero not blanked, then back to zero
        load_a = 1'b1; bcd_a = 16'h1A05;
        step();
        load_a = 1'b0;
        wait_fd(n_steps);
        check_frame("v1A05", 7'b1101101, 7'b0111111, 7'b1000000, 7'b0000110, 1'b1);
        load_a = 1'b1; bcd_a = 16'h0000;
        step();
        load_a = 1'b0;
        wait_fd(n_steps);
        check_frame("v0000", 7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0);

        // 4: last load before the wrap wins; load on the wrap edge is bypassed in
        step(); step();
        load_a = 1'b1; bcd_a = 16'h1111;
        step();
        load_a = 1'b0;
        repeat (5) step();
        load_a = 1'b1; bcd_a = 16'h2222;
        step();
        load_a = 1'b0;
        wait_fd(n_steps);
        check_frame("v2222", 7'b1011011, 7'b1011011, 7'b1011011, 7'b1011011, 1'b0);
        repeat (15) step();
        load_a = 1'b1; bcd_a = 16'h3333;
        step();
        load_a = 1'b0;
        chk("wrap-edge load fd", {31'd0, fd_a}, 32'd1);
        check_frame("v3333", 7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111, 1'b0);

        // 5: asynchronous reset with ptr=2 and a pending value
        repeat (8) step();
        chk("pre-reset an", {28'd0, an_a}, 32'h4);
        load_a = 1'b1; bcd_a = 16'h5555;
        step();
        load_a = 1'b0;
        chk("pre-reset seg", {25'd0, seg_a}, 32'h4F);
        #2;
        Reset = 1'b1;
        #1;
        chk("async rst seg", {25'd0, seg_a}, 32'd0);
        chk("async rst an", {28'd0, an_a}, 32'd0);
        chk("async rst fd", {31'd0, fd_a}, 32'd0);
        chk("async rst err", {31'd0, err_a}, 32'd0);
        step();
        Reset = 1'b0;
        step();
        chk("post-rst edge1 an", {28'd0, an_a}, 32'h1);
        chk("post-rst edge1 seg", {25'd0, seg_a}, 32'h3F);
        wait_fd(n_steps);
        chk("post-rst wrap at edge 16", n_steps, 32'd15);
        check_frame("post-rst", 7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0);

        // 6: no blanking
        sel = 1'b1;
        load_b = 1'b1; bcd_b = 16'h0007;
        step();
        load_b = 1'b0;
        wait_fd(n_steps);
        check_frame("nb0007", 7'b0000111, 7'b0111111, 7'b0111111, 7'b0111111, 1'b0);
        chk("nb next fd", {31'd0, o_fd}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
